// File: rtl/uart_pkg.sv
// Shared types for the UART TX arbiter slice.
// FSM state encoding and byte width constant.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_GAP
  } state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin selector: first set bit after last_i, with wrap.
// Ports: req_i vector, last_i index -> grant_o index, any_o.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] grant_o,
  output logic          any_o
);

  logic [IW-1:0] sel;

  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    sel     = '0;
    for (int k = 1; k <= N; k++) begin
      sel = IW'((int'(last_i) + k) % N);
      if (!any_o && req_i[sel]) begin
        any_o   = 1'b1;
        grant_o = sel;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet round-robin arbiter onto the uart_system TX FIFO port.
// Ports: req_* streams in, w_data/wr_uart out, tx_full in, status out.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_BYTES = 64,
  parameter int TIMEOUT   = 1024,
  parameter int GAP_CYC   = 2,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [8*N_REQ-1:0]    req_data,
  input  logic [N_REQ-1:0]      req_last,
  output logic [N_REQ-1:0]      req_ready,
  output logic [DATA_W-1:0]     w_data,
  output logic                  wr_uart,
  input  logic                  tx_full,
  output logic                  grant_valid,
  output logic [IW-1:0]         grant_id,
  output logic                  pkt_done,
  output logic                  trunc_err,
  output logic                  tout_err
);

  localparam int BW = $clog2(MAX_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYC + 2);
  localparam int GEND = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

  state_e        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] last_q, last_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          pd_q, pd_d;
  logic          tr_q, tr_d;
  logic          to_q, to_d;

  logic [IW-1:0] pick;
  logic          any;
  logic          v_g, l_g;
  logic [7:0]    d_g;
  logic          in_xfer, xfer, done;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req_i   (req_valid),
    .last_i  (last_q),
    .grant_o (pick),
    .any_o   (any)
  );

  assign v_g = req_valid[grant_q];
  assign l_g = req_last[grant_q];
  assign d_g = req_data[8*grant_q +: 8];

  // Gated by rst so a reset cycle never moves a byte.
  assign in_xfer = rst && (state_q == ST_XFER);
  assign xfer    = in_xfer && v_g && !tx_full;

  always_comb begin
    req_ready = '0;
    if (in_xfer && !tx_full) req_ready[grant_q] = 1'b1;
  end

  assign wr_uart     = xfer;
  assign w_data      = xfer ? d_g : '0;
  assign grant_valid = in_xfer;
  assign grant_id    = grant_q;
  assign pkt_done    = pd_q;
  assign trunc_err   = tr_q;
  assign tout_err    = to_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    byte_d  = byte_q;
    idle_d  = idle_q;
    gap_d   = gap_q;
    pd_d    = 1'b0;
    tr_d    = 1'b0;
    to_d    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (any) begin
          grant_d = pick;
          last_d  = pick;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (xfer) begin
          byte_d = byte_q + BW'(1);
          idle_d = '0;
          if (l_g) begin
            pd_d = 1'b1;
            done = 1'b1;
          end else if (byte_q == BW'(MAX_BYTES - 1)) begin
            tr_d = 1'b1;
            done = 1'b1;
          end
        end else if (!v_g) begin
          if (idle_q == TW'(TIMEOUT - 1)) begin
            to_d = 1'b1;
            done = 1'b1;
          end else begin
            idle_d = idle_q + TW'(1);
          end
        end
        if (done) begin
          byte_d  = '0;
          idle_d  = '0;
          gap_d   = '0;
          state_d = (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_q == GW'(GEND)) begin
          gap_d   = '0;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IW'(N_REQ - 1);
      byte_q  <= '0;
      idle_q  <= '0;
      gap_q   <= '0;
      pd_q    <= 1'b0;
      tr_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      byte_q  <= byte_d;
      idle_q  <= idle_d;
      gap_q   <= gap_d;
      pd_q    <= pd_d;
      tr_q    <= tr_d;
      to_q    <= to_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter.
// Byte-source queues per requester, capture of every wr_uart byte.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  w_data;
  logic        wr_uart;
  logic        tx_full;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic        pkt_done, trunc_err, tout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ(4), .MAX_BYTES(64), .TIMEOUT(16), .GAP_CYC(2)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready),
    .w_data(w_data), .wr_uart(wr_uart), .tx_full(tx_full),
    .grant_valid(grant_valid), .grant_id(grant_id),
    .pkt_done(pkt_done), .trunc_err(trunc_err),
    .tout_err(tout_err)
  );

  logic [8:0] q [4][$];
  int cap_d[$], cap_i[$], cap_c[$];
  int nvec = 0, nerr = 0;
  int cyc = 0, viol = 0;
  int npd, ntr, nto, pd_c, tr_c, to_c;
  logic [3:0] hs;

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (q[i].size() > 0) begin
        req_valid[i]     = 1'b1;
        req_data[8*i+:8] = q[i][0][7:0];
        req_last[i]      = q[i][0][8];
      end else begin
        req_valid[i]     = 1'b0;
        req_data[8*i+:8] = 8'h00;
        req_last[i]      = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    hs = req_valid & req_ready;
    if (wr_uart) begin
      cap_d.push_back(int'(w_data));
      cap_i.push_back(int'(grant_id));
      cap_c.push_back(cyc);
    end else if (w_data != 8'h00) viol++;
    if (wr_uart != (|hs)) viol++;
    if (tx_full && (wr_uart || req_ready != 4'h0)) viol++;
    if (req_ready != 4'h0 && !grant_valid) viol++;
    if (pkt_done)  begin npd++; pd_c = cyc; end
    if (trunc_err) begin ntr++; tr_c = cyc; end
    if (tout_err)  begin nto++; to_c = cyc; end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++)
      if (hs[i]) void'(q[i].pop_front());
    drive();
  endtask

  task automatic clr();
    cap_d.delete(); cap_i.delete(); cap_c.delete();
    npd = 0; ntr = 0; nto = 0;
    pd_c = -1; tr_c = -1; to_c = -1;
    viol = 0;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 4; i++) q[i].delete();
    drive();
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    clr();
  endtask

  task automatic run_bytes(input int n, input int budget);
    int k;
    k = 0;
    while (cap_d.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("budget", cap_d.size(), n);
  endtask

  task automatic push_pkt(input int r, input int b0, input int n,
                          input bit last);
    for (int j = 0; j < n; j++)
      q[r].push_back({last && (j == n - 1), 8'(b0 + j)});
  endtask

  int e2d[8] = '{'hA0, 'hA1, 'hB0, 'hB1, 'hA2, 'hA3, 'hB2, 'hB3};
  int e2i[8] = '{1, 1, 3, 3, 1, 1, 3, 3};
  int t0;

  initial begin
    rst = 1'b0;
    tx_full = 1'b0;
    for (int i = 0; i < 4; i++) q[i].delete();
    drive();
    clr();
    repeat (3) tick();
    chk("rst_ready", req_ready, 0);
    chk("rst_wr", wr_uart, 0);
    chk("rst_wdata", w_data, 0);
    chk("rst_gv", grant_valid, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_pulse", {pkt_done, trunc_err, tout_err}, 0);
    rst = 1'b1;
    clr();

    // three 3-byte packets from requesters 0,1,2
    push_pkt(0, 'h10, 3, 1);
    push_pkt(1, 'h20, 3, 1);
    push_pkt(2, 'h30, 3, 1);
    drive();
    run_bytes(9, 100);
    for (int j = 0; j < 9; j++) begin
      chk($sformatf("t1_d%0d", j), cap_d[j], 'h10 * (j/3 + 1) + j%3);
      chk($sformatf("t1_i%0d", j), cap_i[j], j/3);
    end
    chk("t1_gap01", cap_c[3] - cap_c[2], 4);
    chk("t1_gap12", cap_c[6] - cap_c[5], 4);
    chk("t1_burst", cap_c[2] - cap_c[0], 2);
    repeat (3) tick();
    chk("t1_pd", npd, 3);
    chk("t1_pdcyc", pd_c, cap_c[8] + 1);
    chk("t1_viol", viol, 0);

    // requesters 1 and 3 always valid: 1,3,1,3
    do_reset();
    push_pkt(1, 'hA0, 2, 1);
    push_pkt(1, 'hA2, 2, 1);
    push_pkt(3, 'hB0, 2, 1);
    push_pkt(3, 'hB2, 2, 1);
    drive();
    run_bytes(8, 100);
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("t2_d%0d", j), cap_d[j], e2d[j]);
      chk($sformatf("t2_i%0d", j), cap_i[j], e2i[j]);
    end
    chk("t2_viol", viol, 0);

    // tx_full stall mid-packet
    do_reset();
    push_pkt(0, 'h40, 6, 1);
    drive();
    run_bytes(2, 20);
    tx_full = 1'b1;
    repeat (5) tick();
    chk("t3_stall", cap_d.size(), 2);
    tx_full = 1'b0;
    run_bytes(6, 20);
    for (int j = 0; j < 6; j++)
      chk($sformatf("t3_d%0d", j), cap_d[j], 'h40 + j);
    chk("t3_resume", cap_c[2] - cap_c[1], 6);
    chk("t3_viol", viol, 0);

    // 70 bytes with no last: truncation at 64
    do_reset();
    push_pkt(2, 1, 70, 0);
    drive();
    run_bytes(70, 200);
    for (int j = 0; j < 70; j++)
      if (cap_d[j] != j + 1 || cap_i[j] != 2) viol++;
    chk("t4_b64", cap_d[63], 64);
    chk("t4_b65", cap_d[64], 65);
    chk("t4_trc", ntr, 1);
    chk("t4_trcyc", tr_c, cap_c[63] + 1);
    chk("t4_gap", cap_c[64] - cap_c[63], 4);
    repeat (25) tick();
    chk("t4_tout", nto, 1);
    chk("t4_pd", npd, 0);
    chk("t4_viol", viol, 0);

    // timeout after one byte, then requester 1
    do_reset();
    push_pkt(0, 'h50, 1, 0);
    push_pkt(1, 'h60, 2, 1);
    drive();
    run_bytes(3, 100);
    chk("t5_d0", cap_d[0], 'h50);
    chk("t5_i0", cap_i[0], 0);
    chk("t5_d1", cap_d[1], 'h60);
    chk("t5_i1", cap_i[1], 1);
    chk("t5_tout", nto, 1);
    chk("t5_tocyc", to_c, cap_c[0] + 17);
    chk("t5_next", cap_c[1], cap_c[0] + 20);
    chk("t5_viol", viol, 0);

    // reset mid-packet
    do_reset();
    push_pkt(3, 'h70, 6, 1);
    drive();
    run_bytes(2, 20);
    clr();
    rst = 1'b0;
    #1;
    chk("t6_wr", wr_uart, 0);
    chk("t6_gv", grant_valid, 0);
    chk("t6_rdy", req_ready, 0);
    tick();
    chk("t6_gid", grant_id, 0);
    chk("t6_q3", q[3].size(), 4);
    rst = 1'b1;
    push_pkt(0, 'h80, 1, 1);
    drive();
    run_bytes(1, 20);
    chk("t6_d0", cap_d[0], 'h80);
    chk("t6_i0", cap_i[0], 0);
    t0 = cap_d.size();
    run_bytes(t0 + 4, 40);
    chk("t6_rest", cap_d[1], 'h72);
    chk("t6_viol", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
